// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common data bus arbiter.
// Default tag widths, the completion entry layout and a constant clog2.
package cdb_pkg;

    localparam int PR_W_DEF = 6;
    localparam int AR_W_DEF = 5;

    typedef struct packed {
        logic [PR_W_DEF-1:0] pr_idx;
        logic [AR_W_DEF-1:0] ar_idx;
        logic                exception;
    } cdb_entry_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cdb_fu_queue.sv
// Single-channel circular completion FIFO with synchronous clear.
// Push into a full queue and pop from an empty one are ignored.
module cdb_fu_queue
    import cdb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = cdb_entry_t
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        push,
    input  logic                        pop,
    input  entry_t                      push_data,
    output entry_t                      head,
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W = clog2(DEPTH + 1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_push = push && (count_q != CNT_W'(DEPTH));
        do_pop  = pop && (count_q != '0);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = next_ptr(tail_q);
            if (do_pop)  head_d = next_ptr(head_q);
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        if (!reset && !clear && do_push) begin
            mem_q[tail_q] <= push_data;
        end
    end

    assign head  = mem_q[head_q];
    assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus: per-FU completion queues arbitrated round-robin
// onto NUM_CDB registered broadcast lanes, with back-pressure and flush.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU  = 6,
    parameter int NUM_CDB = 2,
    parameter int Q_DEPTH = 2,
    parameter int PR_W    = PR_W_DEF,
    parameter int AR_W    = AR_W_DEF,
    parameter int FU_ID_W = clog2(NUM_FU)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_FU-1:0]          fu_valid,
    input  logic [NUM_FU*PR_W-1:0]     fu_pr_idx,
    input  logic [NUM_FU*AR_W-1:0]     fu_ar_idx,
    input  logic [NUM_FU-1:0]          fu_exception,
    output logic [NUM_FU-1:0]          fu_ready,
    output logic [NUM_CDB-1:0]         cdb_valid,
    output logic [NUM_CDB*PR_W-1:0]    cdb_pr_tag,
    output logic [NUM_CDB*AR_W-1:0]    cdb_ar_tag,
    output logic [NUM_CDB-1:0]         cdb_exception,
    output logic [NUM_CDB*FU_ID_W-1:0] cdb_fu_id
);

    localparam int CNT_W = clog2(Q_DEPTH + 1);

    typedef struct packed {
        logic [PR_W-1:0] pr_idx;
        logic [AR_W-1:0] ar_idx;
        logic            exception;
    } entry_t;

    logic [CNT_W-1:0]   count [NUM_FU];
    entry_t             head [NUM_FU];
    logic [NUM_FU-1:0]  push;
    logic [NUM_FU-1:0]  pop;
    logic [NUM_FU-1:0]  nonempty;
    logic [NUM_FU-1:0]  rotated;

    logic [NUM_CDB-1:0] gnt_valid;
    logic [FU_ID_W-1:0] gnt_fu [NUM_CDB];
    entry_t             lane_sel [NUM_CDB];
    logic [NUM_CDB-1:0] slot;
    logic [FU_ID_W-1:0] last_fu;

    logic [FU_ID_W-1:0]         rr_ptr_q;
    logic [FU_ID_W-1:0]         rr_ptr_d;
    logic [NUM_CDB-1:0]         cdb_valid_q;
    logic [NUM_CDB-1:0]         cdb_valid_d;
    logic [NUM_CDB*PR_W-1:0]    cdb_pr_q;
    logic [NUM_CDB*PR_W-1:0]    cdb_pr_d;
    logic [NUM_CDB*AR_W-1:0]    cdb_ar_q;
    logic [NUM_CDB*AR_W-1:0]    cdb_ar_d;
    logic [NUM_CDB-1:0]         cdb_exc_q;
    logic [NUM_CDB-1:0]         cdb_exc_d;
    logic [NUM_CDB*FU_ID_W-1:0] cdb_fu_q;
    logic [NUM_CDB*FU_ID_W-1:0] cdb_fu_d;

    function automatic logic [FU_ID_W-1:0] wrap_add(
        input logic [FU_ID_W-1:0] base,
        input int                 k
    );
        int s;
        s = int'(base) + k;
        if (s >= NUM_FU) s = s - NUM_FU;
        return FU_ID_W'(s);
    endfunction

    for (genvar i = 0; i < NUM_FU; i++) begin : g_q
        entry_t in_e;

        assign in_e = '{
            pr_idx:    fu_pr_idx[i*PR_W +: PR_W],
            ar_idx:    fu_ar_idx[i*AR_W +: AR_W],
            exception: fu_exception[i]
        };
        // Ready looks only at the registered count, never at this cycle's pop.
        assign fu_ready[i] = (count[i] < CNT_W'(Q_DEPTH));
        assign push[i]     = fu_valid[i] && fu_ready[i] && !flush;
        assign nonempty[i] = (count[i] != '0);

        cdb_fu_queue #(
            .DEPTH   (Q_DEPTH),
            .entry_t (entry_t)
        ) u_q (
            .clock     (clock),
            .reset     (reset),
            .clear     (flush),
            .push      (push[i]),
            .pop       (pop[i]),
            .push_data (in_e),
            .head      (head[i]),
            .count     (count[i])
        );
    end

    // Bit k of rotated is FU (rr_ptr + k) mod NUM_FU.
    assign rotated = NUM_FU'({nonempty, nonempty} >> rr_ptr_q);

    always_comb begin
        gnt_valid = '0;
        slot      = NUM_CDB'(1);
        last_fu   = rr_ptr_q;
        for (int j = 0; j < NUM_CDB; j++) gnt_fu[j] = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (rotated[k] && (slot != '0)) begin
                for (int j = 0; j < NUM_CDB; j++) begin
                    if (slot[j]) begin
                        gnt_valid[j] = 1'b1;
                        gnt_fu[j]    = wrap_add(rr_ptr_q, k);
                    end
                end
                last_fu = wrap_add(rr_ptr_q, k);
                slot    = slot << 1;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            for (int j = 0; j < NUM_CDB; j++) begin
                if (gnt_valid[j] && (gnt_fu[j] == FU_ID_W'(i))) pop[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_CDB; j++) begin
            lane_sel[j] = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (gnt_fu[j] == FU_ID_W'(i)) lane_sel[j] = head[i];
            end
        end
    end

    // Ungranted lanes keep their old data; flush drops grants but keeps rr_ptr.
    always_comb begin
        cdb_valid_d = '0;
        cdb_pr_d    = cdb_pr_q;
        cdb_ar_d    = cdb_ar_q;
        cdb_exc_d   = cdb_exc_q;
        cdb_fu_d    = cdb_fu_q;
        rr_ptr_d    = rr_ptr_q;
        if (!flush) begin
            cdb_valid_d = gnt_valid;
            if (gnt_valid != '0) rr_ptr_d = wrap_add(last_fu, 1);
            for (int j = 0; j < NUM_CDB; j++) begin
                if (gnt_valid[j]) begin
                    cdb_pr_d[j*PR_W +: PR_W]       = lane_sel[j].pr_idx;
                    cdb_ar_d[j*AR_W +: AR_W]       = lane_sel[j].ar_idx;
                    cdb_exc_d[j]                   = lane_sel[j].exception;
                    cdb_fu_d[j*FU_ID_W +: FU_ID_W] = gnt_fu[j];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_pr_q    <= '0;
            cdb_ar_q    <= '0;
            cdb_exc_q   <= '0;
            cdb_fu_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_pr_q    <= cdb_pr_d;
            cdb_ar_q    <= cdb_ar_d;
            cdb_exc_q   <= cdb_exc_d;
            cdb_fu_q    <= cdb_fu_d;
        end
    end

    assign cdb_valid     = cdb_valid_q;
    assign cdb_pr_tag    = cdb_pr_q;
    assign cdb_ar_tag    = cdb_ar_q;
    assign cdb_exception = cdb_exc_q;
    assign cdb_fu_id     = cdb_fu_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model plus directed literals.
// Instance u0 uses two lanes, instance u1 a single lane for back-pressure.
module tb_cdb_arbiter;

    logic clk;
    logic reset;

    logic        flush0, flush1;
    logic [5:0]  v0, ex0, rdy0, v1, ex1, rdy1;
    logic [35:0] pr0, pr1;
    logic [29:0] ar0, ar1;

    logic [1:0]  cv0, cexc0;
    logic [11:0] cpr0;
    logic [9:0]  car0;
    logic [5:0]  cfu0;

    logic [0:0]  cv1, cexc1;
    logic [5:0]  cpr1;
    logic [4:0]  car1;
    logic [2:0]  cfu1;

    int errors = 0;
    int checks = 0;

    // Model: entry = {pr[5:0], ar[4:0], exc}; queue index = inst*6 + fu.
    logic [11:0] mq [12][$];
    logic [1:0]  ev [2];
    logic [11:0] edat [2][2];
    int          efu [2][2];
    int          rr [2];
    bit          model_on = 0;

    bit seen50 = 0;
    int prev_fu1 = -1;
    int alt_err = 0;
    int bcast1 = 0;

    cdb_arbiter u0 (
        .clock(clk), .reset(reset), .flush(flush0),
        .fu_valid(v0), .fu_pr_idx(pr0), .fu_ar_idx(ar0),
        .fu_exception(ex0), .fu_ready(rdy0),
        .cdb_valid(cv0), .cdb_pr_tag(cpr0), .cdb_ar_tag(car0),
        .cdb_exception(cexc0), .cdb_fu_id(cfu0)
    );

    cdb_arbiter #(.NUM_CDB(1)) u1 (
        .clock(clk), .reset(reset), .flush(flush1),
        .fu_valid(v1), .fu_pr_idx(pr1), .fu_ar_idx(ar1),
        .fu_exception(ex1), .fu_ready(rdy1),
        .cdb_valid(cv1), .cdb_pr_tag(cpr1), .cdb_ar_tag(car1),
        .cdb_exception(cexc1), .cdb_fu_id(cfu1)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input int ncdb, input logic rst,
                              input logic fl, input logic [5:0] v,
                              input logic [35:0] pr, input logic [29:0] ar,
                              input logic [5:0] ex);
        bit rdy [6];
        int lane;
        int f;
        for (int i = 0; i < 6; i++) rdy[i] = mq[k*6+i].size() < 2;
        if (rst) begin
            for (int i = 0; i < 6; i++) mq[k*6+i].delete();
            rr[k] = 0;
            ev[k] = 2'b00;
            for (int j = 0; j < 2; j++) begin
                edat[k][j] = '0;
                efu[k][j] = 0;
            end
        end else if (fl) begin
            for (int i = 0; i < 6; i++) mq[k*6+i].delete();
            ev[k] = 2'b00;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (v[i]) begin
                    checks++;
                    if (!rdy[i]) begin
                        errors++;
                        $display("FAIL protocol: inst %0d fu %0d valid while not ready", k, i);
                    end
                end
            end
            ev[k] = 2'b00;
            lane = 0;
            for (int s = 0; s < 6; s++) begin
                f = (rr[k] + s) % 6;
                if (lane < ncdb && mq[k*6+f].size() > 0) begin
                    ev[k][lane] = 1'b1;
                    edat[k][lane] = mq[k*6+f].pop_front();
                    efu[k][lane] = f;
                    lane++;
                end
            end
            if (lane > 0) rr[k] = (efu[k][lane-1] + 1) % 6;
            for (int i = 0; i < 6; i++) begin
                if (v[i] && rdy[i]) mq[k*6+i].push_back({pr[i*6 +: 6], ar[i*5 +: 5], ex[i]});
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 2, reset, flush0, v0, pr0, ar0, ex0);
        model_step(1, 1, reset, flush1, v1, pr1, ar1, ex1);
        if (reset) model_on = 1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int i = 0; i < 6; i++) begin
                chk("ready0", int'(rdy0[i]), int'(mq[i].size() < 2));
                chk("ready1", int'(rdy1[i]), int'(mq[6+i].size() < 2));
            end
            chk("valid0", int'(cv0), int'(ev[0]));
            chk("valid1", int'(cv1), int'(ev[1][0]));
            for (int j = 0; j < 2; j++) begin
                if (ev[0][j]) begin
                    chk("data0", int'({cpr0[j*6 +: 6], car0[j*5 +: 5], cexc0[j]}),
                        int'(edat[0][j]));
                    chk("fuid0", int'(cfu0[j*3 +: 3]), efu[0][j]);
                end
                if (cv0[j] && cpr0[j*6 +: 6] == 6'd50) seen50 = 1;
            end
            if (ev[1][0]) begin
                chk("data1", int'({cpr1, car1, cexc1}), int'(edat[1][0]));
                chk("fuid1", int'(cfu1), efu[1][0]);
            end
            if (cv1[0]) begin
                bcast1++;
                if (prev_fu1 >= 0 && prev_fu1 == int'(cfu1)) alt_err++;
                prev_fu1 = int'(cfu1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put0(input int i, input int pr, input int ar, input bit e);
        logic [31:0] p;
        logic [31:0] a;
        p = pr;
        a = ar;
        v0[i] = 1'b1;
        pr0[i*6 +: 6] = p[5:0];
        ar0[i*5 +: 5] = a[4:0];
        ex0[i] = e;
    endtask

    task automatic clr0();
        v0 = '0;
        ex0 = '0;
    endtask

    int push1;
    int c0;
    int c1;
    bit sawfull;

    initial begin
        reset = 1;
        flush0 = 0; flush1 = 0;
        v0 = '0; pr0 = '0; ar0 = '0; ex0 = '0;
        v1 = '0; pr1 = '0; ar1 = '0; ex1 = '0;
        tick();
        tick();
        reset = 0;
        @(negedge clk);
        chk("rst_valid", int'(cv0), 0);
        chk("rst_ready", int'(rdy0), 63);
        chk("rst_ready_u1", int'(rdy1), 63);
        repeat (10) tick();
        @(negedge clk);
        chk("idle_valid", int'(cv0), 0);

        // Contention: all six FUs at once, rr_ptr = 0.
        tick();
        for (int i = 0; i < 6; i++) put0(i, 10 + i, i, 1'b0);
        tick();
        clr0();
        tick();
        @(negedge clk);
        chk("cont1_valid", int'(cv0), 3);
        chk("cont1_pr", int'(cpr0), (11 << 6) | 10);
        chk("cont1_fu", int'(cfu0), (1 << 3) | 0);
        tick();
        @(negedge clk);
        chk("cont2_pr", int'(cpr0), (13 << 6) | 12);
        tick();
        @(negedge clk);
        chk("cont3_pr", int'(cpr0), (15 << 6) | 14);
        chk("cont3_fu", int'(cfu0), (5 << 3) | 4);
        tick();
        @(negedge clk);
        chk("cont_done", int'(cv0), 0);

        // rr_ptr wrapped to 0: FU0 must win over FU5.
        tick();
        put0(0, 20, 1, 1'b0);
        put0(5, 25, 2, 1'b0);
        tick();
        clr0();
        tick();
        @(negedge clk);
        chk("wrap_fu", int'(cfu0), (5 << 3) | 0);
        chk("wrap_pr", int'(cpr0), (25 << 6) | 20);

        // Single result from FU3.
        tick();
        put0(3, 17, 4, 1'b0);
        tick();
        clr0();
        tick();
        @(negedge clk);
        chk("single_valid", int'(cv0), 1);
        chk("single_pr", int'(cpr0[5:0]), 17);
        chk("single_ar", int'(car0[4:0]), 4);
        chk("single_fu", int'(cfu0[2:0]), 3);
        chk("single_exc", int'(cexc0[0]), 0);

        // Exception travels with its entry.
        tick();
        put0(4, 33, 7, 1'b1);
        tick();
        clr0();
        tick();
        @(negedge clk);
        chk("exc_valid", int'(cv0), 1);
        chk("exc_pr", int'(cpr0[5:0]), 33);
        chk("exc_bit", int'(cexc0[0]), 1);
        chk("exc_fu", int'(cfu0[2:0]), 4);

        // Flush with four queued entries and a new FU2 result.
        tick();
        for (int i = 0; i < 4; i++) put0(i, 40 + i, i, 1'b0);
        tick();
        clr0();
        put0(2, 50, 3, 1'b0);
        flush0 = 1;
        tick();
        clr0();
        flush0 = 0;
        @(negedge clk);
        chk("flush_valid", int'(cv0), 0);
        chk("flush_ready", int'(rdy0), 63);
        repeat (6) tick();
        @(negedge clk);
        chk("flush_idle", int'(cv0), 0);
        chk("flush_no50", int'(seen50), 0);

        // Reset while queues hold entries.
        tick();
        for (int i = 0; i < 6; i++) put0(i, 60 + i, i, 1'b1);
        tick();
        clr0();
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        chk("mrst_valid", int'(cv0), 0);
        chk("mrst_pr", int'(cpr0), 0);
        chk("mrst_ar", int'(car0), 0);
        chk("mrst_exc", int'(cexc0), 0);
        chk("mrst_fu", int'(cfu0), 0);
        chk("mrst_ready", int'(rdy0), 63);
        repeat (4) tick();

        // Single-lane back-pressure: FU0 and FU1 push whenever ready.
        push1 = 0; c0 = 0; c1 = 0; sawfull = 0;
        prev_fu1 = -1;
        bcast1 = 0;
        tick();
        for (int n = 0; n < 30; n++) begin
            v1 = '0;
            if (!rdy1[0]) sawfull = 1;
            if (rdy1[0]) begin
                v1[0] = 1'b1;
                pr1[5:0] = 6'(c0);
                ar1[4:0] = 5'(c0);
                c0++;
                push1++;
            end
            if (rdy1[1]) begin
                v1[1] = 1'b1;
                pr1[11:6] = 6'(32 + c1);
                ar1[9:5] = 5'(c1);
                c1++;
                push1++;
            end
            tick();
        end
        v1 = '0;
        repeat (8) tick();
        @(negedge clk);
        chk("bp_full_seen", int'(sawfull), 1);
        chk("bp_alternate", alt_err, 0);
        chk("bp_count", bcast1, push1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
